// File: rtl/csr_unit.sv
// csr_unit -- execute-stage sequencer for the CSR register file access port.
//
// Accepts one Zicsr (CSRRW/CSRRS/CSRRC) or trap (ECALL/MRET) instruction per
// request handshake. It runs the read-modify-write on the CSR file as a
// multi-cycle sequence and returns the old CSR value. For traps it also
// returns a PC redirect. It is the sole master of the CSR file port.
//
// Optional feature macro: CSR_UNIT_ILLEGAL_CHK_EN
//   When defined, CSR ops are only allowed to 0x300, 0x305, 0x341 and 0x342.
//   Any other address completes straight away with resp_illegal=1 and never
//   touches the port. When undefined, every address is accessed and
//   resp_illegal stays 0.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   req_*              request channel (valid/ready). op: 0 RW, 1 RS, 2 RC,
//                      3 ECALL, 4 MRET, 5-7 reserved
//   resp_*             response channel (valid/ready). rdata = old CSR value,
//                      redirect/target = fetch redirect for ECALL/MRET
//   csr_id/re/we/wdata CSR file access strobes (registered, one cycle each)
//   ecall/mret/epc     trap strobes to the CSR file. On ecall, csr_wdata
//                      carries the mcause value.
//   csr_rdata          combinational read data from the CSR file. It shows
//                      mtvec during ecall and mepc during mret.
module csr_unit #(
  parameter int unsigned            XLEN        = 64,
  parameter logic [XLEN-1:0]        ECALL_CAUSE = 64'd11
) (
  input  logic            clk,
  input  logic            rst,
  // request
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_csr,
  input  logic [XLEN-1:0] req_src,
  input  logic            req_src_zero,
  input  logic [XLEN-1:0] req_pc,
  // response
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_redirect,
  output logic [XLEN-1:0] resp_target,
  output logic            resp_illegal,
  // CSR file port
  output logic [11:0]     csr_id,
  output logic            csr_re,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_wdata,
  output logic            ecall,
  output logic            mret,
  output logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] csr_rdata
);

  localparam logic [2:0] OP_RW    = 3'd0;
  localparam logic [2:0] OP_RS    = 3'd1;
  localparam logic [2:0] OP_RC    = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    TRAP  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   src_q;
  logic              src_zero_q;
  logic [XLEN-1:0]   old_q;

  // Address legality. In the default build this is constant 1, so the
  // illegal branch below is dead logic and resp_illegal stays at its reset
  // value of 0.
  logic addr_ok;
`ifdef CSR_UNIT_ILLEGAL_CHK_EN
  always_comb begin
    addr_ok = 1'b0;
    case (req_csr)
      12'h300, 12'h305, 12'h341, 12'h342: addr_ok = 1'b1;
      default:                            addr_ok = 1'b0;
    endcase
  end
`else
  always_comb addr_ok = 1'b1;
`endif

  logic is_csr_op;
  assign is_csr_op = (req_op == OP_RW) || (req_op == OP_RS) || (req_op == OP_RC);

  // RS/RC with a zero rs1/uimm field must not write: it is a pure read.
  logic write_req;
  assign write_req = (op_q == OP_RW) || !src_zero_q;

  // New value computed from the live read data at the end of READ. The
  // result is registered straight into csr_wdata for the WRITE cycle.
  logic [XLEN-1:0] new_val;
  always_comb begin
    new_val = src_q;
    case (op_q)
      OP_RS:   new_val = csr_rdata | src_q;
      OP_RC:   new_val = csr_rdata & ~src_q;
      default: new_val = src_q;
    endcase
  end

  // All outputs are registered. Each strobe is set on the edge that enters
  // its state and cleared on the edge that leaves it, so it is high for
  // exactly the one cycle spent in that state. csr_id doubles as the
  // latched CSR address while READ/WRITE are in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= '0;
      src_q         <= '0;
      src_zero_q    <= 1'b0;
      old_q         <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_redirect <= 1'b0;
      resp_target   <= '0;
      resp_illegal  <= 1'b0;
      csr_id        <= '0;
      csr_re        <= 1'b0;
      csr_we        <= 1'b0;
      csr_wdata     <= '0;
      ecall         <= 1'b0;
      mret          <= 1'b0;
      epc           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            src_q      <= req_src;
            src_zero_q <= req_src_zero;
            req_ready  <= 1'b0;
            if (is_csr_op) begin
              if (!addr_ok) begin
                state        <= RESP;
                resp_valid   <= 1'b1;
                resp_illegal <= 1'b1;
              end else begin
                state  <= READ;
                csr_re <= 1'b1;
                csr_id <= req_csr;
              end
            end else if (req_op == OP_ECALL) begin
              state     <= TRAP;
              ecall     <= 1'b1;
              epc       <= req_pc;
              csr_wdata <= ECALL_CAUSE;
            end else if (req_op == OP_MRET) begin
              state <= TRAP;
              mret  <= 1'b1;
            end else begin
              // reserved op: complete immediately with an all-zero response
              state      <= RESP;
              resp_valid <= 1'b1;
            end
          end
        end

        READ: begin
          csr_re <= 1'b0;
          old_q  <= csr_rdata;
          if (write_req) begin
            state     <= WRITE;
            csr_we    <= 1'b1;
            csr_wdata <= new_val;
          end else begin
            state      <= RESP;
            csr_id     <= '0;
            resp_valid <= 1'b1;
            resp_rdata <= csr_rdata;
          end
        end

        WRITE: begin
          state      <= RESP;
          csr_we     <= 1'b0;
          csr_id     <= '0;
          csr_wdata  <= '0;
          resp_valid <= 1'b1;
          resp_rdata <= old_q;
        end

        TRAP: begin
          // The CSR file presents mtvec (ecall) or mepc (mret) while the
          // trap strobe is up. That value is the redirect target.
          state         <= RESP;
          ecall         <= 1'b0;
          mret          <= 1'b0;
          epc           <= '0;
          csr_wdata     <= '0;
          resp_valid    <= 1'b1;
          resp_redirect <= 1'b1;
          resp_target   <= csr_rdata;
        end

        RESP: begin
          if (resp_ready) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_redirect <= 1'b0;
            resp_target   <= '0;
            resp_illegal  <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Execute-stage sequencer that drives the CSR register file's access port (`csr_id`/`csr_re`/`csr_we`/`csr_wdata`/`ecall`/`mret`/`epc`, read data on `csr_rdata`). It accepts one Zicsr or trap instruction per handshake and performs the read-modify-write as a multi-cycle sequence. It returns the old CSR value for `rd`, plus a PC redirect for ECALL/MRET. It sits between the decoder/EXU and the CSR file, and it is the only master of that port.

## Interface
- `XLEN`, 64, datapath width; must match the CSR file.
- `ECALL_CAUSE`, 64'd11, value written to mcause on ECALL (M-mode environment call).

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and able to accept.
- `req_op`  in  3  0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 MRET, 5–7 reserved.
- `req_csr`  in  12  CSR address.
- `req_src`  in  XLEN  operand: rs1 value, or zero-extended uimm for the I-forms (selected upstream).
- `req_src_zero`  in  1  rs1/uimm instruction field is 0.
- `req_pc`  in  XLEN  PC of the instruction.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `resp_rdata`  out  XLEN  old CSR value; 0 for ECALL/MRET/reserved.
- `resp_redirect`  out  1  the fetch must jump to `resp_target`.
- `resp_target`  out  XLEN  mtvec (ECALL) or mepc (MRET).
- `resp_illegal`  out  1  illegal CSR access (see Configuration).
- `csr_id`  out  12; `csr_re`  out  1; `csr_we`  out  1; `csr_wdata`  out  XLEN; `ecall`  out  1; `mret`  out  1; `epc`  out  XLEN.
- `csr_rdata`  in  XLEN  combinational read data from the CSR file.

## Operation
- The FSM states are IDLE, READ, WRITE, TRAP and RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch op, csr, src, src_zero and pc.
  - CSR ops go to READ; ECALL and MRET go to TRAP; reserved ops go to RESP with all response fields 0.
- READ:
  - Assert `csr_re` for exactly one cycle with `csr_id`=latched csr.
  - Register `csr_rdata` as `old`.
  - Next state is WRITE if a write is required, else RESP.
- A write is required when:
  - the op is CSRRW (always), or
  - the op is CSRRS/CSRRC and `req_src_zero`=0.
- WRITE:
  - Assert `csr_we` for exactly one cycle with the same `csr_id`.
  - `csr_wdata` is: CSRRW = src; CSRRS = old | src; CSRRC = old & ~src.
  - Next state is RESP.
- TRAP:
  - Assert `ecall` or `mret` for exactly one cycle.
  - For ECALL, drive `epc`=latched pc and `csr_wdata`=ECALL_CAUSE.
  - Register `csr_rdata` as target: the CSR file presents mtvec on ecall and mepc on mret.
  - Next state is RESP with `resp_redirect`=1.
- RESP:
  - `resp_valid`=1; all resp fields are held stable.
  - Go to IDLE on `resp_ready`.
- Outside its active state, every CSR-port strobe is 0. `csr_id`, `csr_wdata` and `epc` are 0 in IDLE and RESP.
- At most one of `csr_re`, `csr_we`, `ecall`, `mret` is high in any cycle.

## Timing
- Reset: state=IDLE; `req_ready`=1 in the cycle after the reset edge.
- Reset values of all other outputs:
  - `resp_valid`, `resp_rdata`, `resp_redirect`, `resp_target`, `resp_illegal` = 0.
  - All CSR-port outputs = 0.
- Reset mid-operation (any state) aborts the sequence. No strobe is asserted after the reset edge. A write or trap already strobed before that edge is not undone.
- Latency from the accept edge to `resp_valid`:
  - CSR op with write: 3 cycles (READ, WRITE, RESP).
  - CSR op without write: 2 cycles.
  - ECALL/MRET: 2 cycles.
  - Reserved op: 1 cycle.
- Throughput:
  - `req_ready`=0 from the accept edge until the cycle after the `resp_valid & resp_ready` edge.
  - A new request is therefore accepted no earlier than the cycle after the response handshake.
  - There are no overlapping transactions.
- `resp_valid` held with `resp_ready`=0: stay in RESP indefinitely; outputs do not change.
- `req_valid` asserted while busy: ignored, not latched.

## Configuration
- `CSR_UNIT_ILLEGAL_CHK_EN` defined:
  - The legal addresses are 0x300, 0x305, 0x341 and 0x342.
  - A CSR op to any other address skips READ and WRITE: no `csr_re`/`csr_we`.
  - It goes IDLE→RESP with `resp_illegal`=1 and `resp_rdata`=0.
- Not defined:
  - All addresses are accessed normally; the CSR file returns 0 for unknown addresses and ignores writes to them.
  - `resp_illegal` is tied to 0.

## Test plan
- **mtvec with CSRRW:** mtvec=0. Send CSRRW csr=0x305 src=0x8000_0100. Required:
  - `csr_re` one cycle, then `csr_we` one cycle with wdata 0x8000_0100.
  - `resp_rdata`=0, `resp_valid` 3 cycles after accept.
  - A following CSRRS with src_zero=1 returns 0x8000_0100 with no `csr_we`.
- **CSRRS/CSRRC on mstatus:** mstatus=0x1800. CSRRS src=0x8 → wdata 0x1808, rdata 0x1800. Then CSRRC src=0x1000 → wdata 0x0808, rdata 0x1808.
- **ECALL:** mtvec=0x8000_0100, req_pc=0x8000_0040. Required:
  - One-cycle `ecall` with epc=0x8000_0040 and wdata=11.
  - `resp_redirect`=1, `resp_target`=0x8000_0100.
  - The CSR file then reads mepc=0x8000_0040 and mcause=11.
- **MRET:** mepc=0x8000_0044. Required: one-cycle `mret`, `resp_target`=0x8000_0044, `resp_redirect`=1, no `csr_we`.
- **Backpressure and reset:**
  - Hold `resp_ready`=0 for 5 cycles: `resp_*` stable and `req_ready`=0 throughout.
  - Assert `rst` while in WRITE: no strobe after the edge; `req_ready`=1 and `resp_valid`=0 the next cycle.
- **With the macro defined:** CSRRW csr=0x7C0. Required: `resp_illegal`=1 after 1 cycle, with `csr_re` and `csr_we` never asserted.
